// File: rtl/multi_alarm_unit_if.sv
// Alarm bank bus: time/tick from the clock core, config and user keys in, status out.
// Latency: pure wiring, no storage.
// Backpressure: none; every input is sampled each cycle and every output is always valid.
interface multi_alarm_unit_if #(
  parameter int NUM_ALARMS  = 4,
  parameter int ALARM_IDX_W = 2
);
  logic                   sec_tick;
  logic [7:0]             current_24_sec;
  logic [7:0]             current_24_min;
  logic [7:0]             current_24_hour;
  logic                   cfg_we;
  logic [ALARM_IDX_W-1:0] cfg_idx;
  logic [7:0]             cfg_sec;
  logic [7:0]             cfg_min;
  logic [7:0]             cfg_hour;
  logic                   cfg_enable;
  logic                   cfg_repeat;
  logic                   snooze;
  logic                   dismiss;
  logic [NUM_ALARMS-1:0]  ringing;
  logic [NUM_ALARMS-1:0]  armed;
  logic                   alarm_buzzer;
  logic [ALARM_IDX_W-1:0] alarm_fired_idx;
  logic                   invalid_cfg;

  modport master (
    output sec_tick, current_24_sec, current_24_min, current_24_hour,
           cfg_we, cfg_idx, cfg_sec, cfg_min, cfg_hour, cfg_enable, cfg_repeat,
           snooze, dismiss,
    input  ringing, armed, alarm_buzzer, alarm_fired_idx, invalid_cfg
  );

  modport slave (
    input  sec_tick, current_24_sec, current_24_min, current_24_hour,
           cfg_we, cfg_idx, cfg_sec, cfg_min, cfg_hour, cfg_enable, cfg_repeat,
           snooze, dismiss,
    output ringing, armed, alarm_buzzer, alarm_fired_idx, invalid_cfg
  );
endinterface

// File: rtl/multi_alarm_unit.sv
// Bank of independent alarm channels with one-shot/daily mode, snooze and ring timeout.
// Latency: trigger/config/key seen at cycle t is reflected on the status outputs at t+1.
// Backpressure: none; inputs are sampled every cycle, outputs decode state registers.
module multi_alarm_unit #(
  parameter int NUM_ALARMS       = 4,
  parameter int ALARM_IDX_W      = 2,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input logic               clk,
  input logic               reset,
  multi_alarm_unit_if.slave bus
);
  localparam int MAX_SEC = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_TIMEOUT_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } hms_t;

  state_e           st_q  [NUM_ALARMS];
  state_e           st_d  [NUM_ALARMS];
  hms_t             tm_q  [NUM_ALARMS];
  hms_t             tm_d  [NUM_ALARMS];
  logic [CNT_W-1:0] cnt_q [NUM_ALARMS];
  logic [CNT_W-1:0] cnt_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] rep_q, rep_d;
  logic [NUM_ALARMS-1:0] match_q, match_d;
  logic [NUM_ALARMS-1:0] match_now;
  logic [NUM_ALARMS-1:0] cfg_sel;
  logic [NUM_ALARMS-1:0] ring_vec, armed_vec;
  logic [ALARM_IDX_W-1:0] fired_idx;
  logic inv_q;

  hms_t cur_time, cfg_time;
  logic cfg_fields_ok, cfg_idx_ok, cfg_ok;

  assign cur_time = {bus.current_24_hour, bus.current_24_min, bus.current_24_sec};
  assign cfg_time = {bus.cfg_hour, bus.cfg_min, bus.cfg_sec};

  assign cfg_fields_ok = (bus.cfg_hour <= 8'd23) && (bus.cfg_min <= 8'd59) && (bus.cfg_sec <= 8'd59);
  assign cfg_idx_ok    = ({{(32-ALARM_IDX_W){1'b0}}, bus.cfg_idx} < 32'(NUM_ALARMS));
  assign cfg_ok        = bus.cfg_we && cfg_fields_ok && cfg_idx_ok;

  // Per-channel time compare and write-select decode.
  always_comb begin
    match_now = '0;
    cfg_sel   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match_now[i] = (cur_time == tm_q[i]);
      cfg_sel[i]   = cfg_ok && (bus.cfg_idx == ALARM_IDX_W'(i));
    end
  end

  // Next-state per channel; priority is config write > dismiss > snooze > tick > trigger.
  always_comb begin
    rep_d   = rep_q;
    match_d = match_now;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      st_d[i]  = st_q[i];
      tm_d[i]  = tm_q[i];
      cnt_d[i] = cnt_q[i];
      if (cfg_sel[i]) begin
        tm_d[i]    = cfg_time;
        rep_d[i]   = bus.cfg_repeat;
        st_d[i]    = bus.cfg_enable ? ST_ARMED : ST_DISABLED;
        cnt_d[i]   = '0;
        // Pre-load the edge detector so writing the present time waits a full day.
        match_d[i] = (cfg_time == cur_time);
      end else begin
        unique case (st_q[i])
          ST_ARMED: begin
            if (match_now[i] && !match_q[i]) begin
              st_d[i]  = ST_RINGING;
              cnt_d[i] = RING_LOAD;
            end
          end
          ST_RINGING: begin
            if (bus.dismiss) begin
              st_d[i]  = rep_q[i] ? ST_ARMED : ST_DISABLED;
              cnt_d[i] = '0;
            end else if (bus.snooze) begin
              st_d[i]  = ST_SNOOZED;
              cnt_d[i] = SNOOZE_LOAD;
            end else if (bus.sec_tick) begin
              if (cnt_q[i] == CNT_ONE) begin
                st_d[i]  = rep_q[i] ? ST_ARMED : ST_DISABLED;
                cnt_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
              end
            end
          end
          ST_SNOOZED: begin
            if (bus.dismiss) begin
              st_d[i]  = rep_q[i] ? ST_ARMED : ST_DISABLED;
              cnt_d[i] = '0;
            end else if (bus.sec_tick) begin
              if (cnt_q[i] == CNT_ONE) begin
                st_d[i]  = ST_RINGING;
                cnt_d[i] = RING_LOAD;
              end else begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
              end
            end
          end
          default: begin
            st_d[i] = ST_DISABLED;
          end
        endcase
      end
    end
  end

  // State, time, counter and edge-detector registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]  <= ST_DISABLED;
        tm_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rep_q   <= '0;
      match_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]  <= st_d[i];
        tm_q[i]  <= tm_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      rep_q   <= rep_d;
      match_q <= match_d;
      inv_q   <= bus.cfg_we && !cfg_ok;
    end
  end

  // Status decode straight from state; lowest-index ringing channel wins.
  always_comb begin
    ring_vec  = '0;
    armed_vec = '0;
    fired_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      ring_vec[i]  = (st_q[i] == ST_RINGING);
      armed_vec[i] = (st_q[i] == ST_ARMED);
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring_vec[i]) fired_idx = ALARM_IDX_W'(i);
    end
  end

  assign bus.ringing         = ring_vec;
  assign bus.armed           = armed_vec;
  assign bus.alarm_buzzer    = |ring_vec;
  assign bus.alarm_fired_idx = fired_idx;
  assign bus.invalid_cfg     = inv_q;
endmodule

// File: tb/tb_multi_alarm_unit.sv
// Self-checking bench for multi_alarm_unit: directed scenarios plus randomized run vs. a model.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_multi_alarm_unit;
  localparam int NA   = 4;
  localparam int IW   = 3;
  localparam int SNZ  = 3;
  localparam int RING = 60;

  localparam int M_OFF  = 0;
  localparam int M_ARM  = 1;
  localparam int M_RING = 2;
  localparam int M_SNZ  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int t_sec = 0;

  multi_alarm_unit_if #(.NUM_ALARMS(NA), .ALARM_IDX_W(IW)) bus ();

  multi_alarm_unit #(
    .NUM_ALARMS(NA), .ALARM_IDX_W(IW), .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(RING)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: alarm time as seconds-of-day, ticks elapsed since entering a timed state.
  int m_st [NA];
  int m_el [NA];
  int m_at [NA];
  bit m_rep [NA];
  bit m_prev [NA];
  bit m_inv;

  task automatic model_reset();
    for (int c = 0; c < NA; c++) begin
      m_st[c] = M_OFF; m_el[c] = 0; m_at[c] = 0; m_rep[c] = 0; m_prev[c] = 0;
    end
    m_inv = 0;
  endtask

  task automatic model_step();
    bit valid;
    bit eq;
    int done_st;
    valid = bus.cfg_we && bus.cfg_hour < 24 && bus.cfg_min < 60 && bus.cfg_sec < 60 && int'(bus.cfg_idx) < NA;
    for (int c = 0; c < NA; c++) begin
      eq = (t_sec == m_at[c]);
      done_st = m_rep[c] ? M_ARM : M_OFF;
      if (valid && int'(bus.cfg_idx) == c) begin
        m_at[c]   = int'(bus.cfg_hour) * 3600 + int'(bus.cfg_min) * 60 + int'(bus.cfg_sec);
        m_rep[c]  = bus.cfg_repeat;
        m_st[c]   = bus.cfg_enable ? M_ARM : M_OFF;
        m_prev[c] = (m_at[c] == t_sec);
      end else begin
        if (m_st[c] == M_RING) begin
          if (bus.dismiss) m_st[c] = done_st;
          else if (bus.snooze) begin m_st[c] = M_SNZ; m_el[c] = 0; end
          else if (bus.sec_tick) begin
            m_el[c]++;
            if (m_el[c] >= RING) m_st[c] = done_st;
          end
        end else if (m_st[c] == M_SNZ) begin
          if (bus.dismiss) m_st[c] = done_st;
          else if (bus.sec_tick) begin
            m_el[c]++;
            if (m_el[c] >= SNZ) begin m_st[c] = M_RING; m_el[c] = 0; end
          end
        end else if (m_st[c] == M_ARM) begin
          if (eq && !m_prev[c]) begin m_st[c] = M_RING; m_el[c] = 0; end
        end
        m_prev[c] = eq;
      end
    end
    m_inv = bus.cfg_we && !valid;
  endtask

  function automatic logic [NA-1:0] m_mask(input int which);
    logic [NA-1:0] r;
    r = '0;
    for (int c = 0; c < NA; c++) r[c] = (m_st[c] == which);
    return r;
  endfunction

  function automatic logic [IW-1:0] m_idx();
    logic [IW-1:0] r;
    r = '0;
    for (int c = NA - 1; c >= 0; c--) if (m_st[c] == M_RING) r = IW'(c);
    return r;
  endfunction

  task automatic set_time(input int s);
    t_sec = s % 86400;
    bus.current_24_hour = 8'(t_sec / 3600);
    bus.current_24_min  = 8'((t_sec / 60) % 60);
    bus.current_24_sec  = 8'(t_sec % 60);
  endtask

  // One clock: model sees the same inputs the DUT samples, then pulses are cleared.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    bus.sec_tick = 0; bus.cfg_we = 0; bus.snooze = 0; bus.dismiss = 0;
  endtask

  task automatic set_cfg(input int idx, input int h, input int m, input int s, input bit en, input bit rep);
    bus.cfg_we = 1; bus.cfg_idx = IW'(idx);
    bus.cfg_hour = 8'(h); bus.cfg_min = 8'(m); bus.cfg_sec = 8'(s);
    bus.cfg_enable = en; bus.cfg_repeat = rep;
  endtask

  // Advance one second together with the tick pulse, then one idle cycle.
  task automatic tick();
    set_time(t_sec + 1);
    bus.sec_tick = 1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ringing !== 4'b0) begin errors++; $display("FAIL reset_ringing got %b exp 0000", bus.ringing); end
    checks++; if (bus.armed !== 4'b0) begin errors++; $display("FAIL reset_armed got %b exp 0000", bus.armed); end
    checks++; if (bus.alarm_buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got %b exp 0", bus.alarm_buzzer); end
    checks++; if (bus.alarm_fired_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.alarm_fired_idx); end
    checks++; if (bus.invalid_cfg !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b exp 0", bus.invalid_cfg); end
    reset = 1;
    model_reset();
    cycle();
  endtask

  task automatic test_one_shot();
    set_time(59); cycle();
    set_cfg(0, 0, 1, 0, 1, 0); cycle();
    checks++; if (bus.armed !== 4'b0001) begin errors++; $display("FAIL oneshot_armed got %b exp 0001", bus.armed); end
    set_time(60); bus.sec_tick = 1; cycle();
    checks++; if (bus.ringing !== 4'b0001) begin errors++; $display("FAIL oneshot_ring got %b exp 0001", bus.ringing); end
    checks++; if (bus.alarm_buzzer !== 1'b1) begin errors++; $display("FAIL oneshot_buzzer got %b exp 1", bus.alarm_buzzer); end
    checks++; if (bus.alarm_fired_idx !== 3'd0) begin errors++; $display("FAIL oneshot_idx got %0d exp 0", bus.alarm_fired_idx); end
    cycle();
    repeat (RING - 1) tick();
    checks++; if (bus.ringing !== 4'b0001) begin errors++; $display("FAIL oneshot_still_ring got %b exp 0001", bus.ringing); end
    tick();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL oneshot_timeout got %b exp 0000", bus.ringing); end
    checks++; if (bus.armed !== 4'b0000) begin errors++; $display("FAIL oneshot_disarm got %b exp 0000", bus.armed); end
  endtask

  task automatic test_dismiss_repeat();
    set_cfg(2, 0, 2, 30, 1, 1); cycle();
    set_time(150); cycle();
    checks++; if (bus.ringing !== 4'b0100) begin errors++; $display("FAIL rep_jump_ring got %b exp 0100", bus.ringing); end
    bus.dismiss = 1; cycle();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL rep_dismiss_ring got %b exp 0000", bus.ringing); end
    checks++; if (bus.armed !== 4'b0100) begin errors++; $display("FAIL rep_dismiss_armed got %b exp 0100", bus.armed); end
    set_time(10); cycle();
    set_time(150); cycle();
    checks++; if (bus.ringing !== 4'b0100) begin errors++; $display("FAIL rep_refire got %b exp 0100", bus.ringing); end
    bus.dismiss = 1; cycle();
  endtask

  task automatic test_snooze();
    set_cfg(1, 0, 3, 0, 1, 0); cycle();
    set_time(179); cycle();
    tick();
    checks++; if (bus.ringing !== 4'b0010) begin errors++; $display("FAIL snz_ring got %b exp 0010", bus.ringing); end
    bus.snooze = 1; cycle();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL snz_quiet got %b exp 0000", bus.ringing); end
    tick(); tick();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL snz_two_ticks got %b exp 0000", bus.ringing); end
    tick();
    checks++; if (bus.ringing !== 4'b0010) begin errors++; $display("FAIL snz_rering got %b exp 0010", bus.ringing); end
    bus.snooze = 1; cycle();
    bus.dismiss = 1; cycle();
    repeat (SNZ + 2) tick();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL snz_dismissed got %b exp 0000", bus.ringing); end
    checks++; if (bus.armed !== 4'b0100) begin errors++; $display("FAIL snz_armed got %b exp 0100", bus.armed); end
  endtask

  task automatic test_multi();
    set_cfg(1, 0, 4, 0, 1, 1); cycle();
    set_cfg(3, 0, 4, 0, 1, 1); cycle();
    set_time(239); cycle();
    tick();
    checks++; if (bus.ringing !== 4'b1010) begin errors++; $display("FAIL multi_ring got %b exp 1010", bus.ringing); end
    checks++; if (bus.alarm_fired_idx !== 3'd1) begin errors++; $display("FAIL multi_idx got %0d exp 1", bus.alarm_fired_idx); end
    bus.snooze = 1; cycle();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL multi_snooze got %b exp 0000", bus.ringing); end
    checks++; if (bus.alarm_buzzer !== 1'b0) begin errors++; $display("FAIL multi_buzz_off got %b exp 0", bus.alarm_buzzer); end
    bus.dismiss = 1; cycle();
    checks++; if (bus.armed !== 4'b1110) begin errors++; $display("FAIL multi_rearm got %b exp 1110", bus.armed); end
  endtask

  task automatic test_invalid();
    set_cfg(0, 24, 0, 0, 1, 0); cycle();
    checks++; if (bus.invalid_cfg !== 1'b1) begin errors++; $display("FAIL inv_hour_pulse got %b exp 1", bus.invalid_cfg); end
    checks++; if (bus.armed !== 4'b1110) begin errors++; $display("FAIL inv_hour_armed got %b exp 1110", bus.armed); end
    cycle();
    checks++; if (bus.invalid_cfg !== 1'b0) begin errors++; $display("FAIL inv_hour_once got %b exp 0", bus.invalid_cfg); end
    set_cfg(5, 0, 0, 0, 1, 0); cycle();
    checks++; if (bus.invalid_cfg !== 1'b1) begin errors++; $display("FAIL inv_idx_pulse got %b exp 1", bus.invalid_cfg); end
    checks++; if (bus.armed !== 4'b1110) begin errors++; $display("FAIL inv_idx_armed got %b exp 1110", bus.armed); end
    cycle();
    checks++; if (bus.invalid_cfg !== 1'b0) begin errors++; $display("FAIL inv_idx_once got %b exp 0", bus.invalid_cfg); end
    set_cfg(0, t_sec / 3600, (t_sec / 60) % 60, t_sec % 60, 1, 0); cycle();
    checks++; if (bus.armed !== 4'b1111) begin errors++; $display("FAIL now_write_armed got %b exp 1111", bus.armed); end
    cycle();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL now_write_noring got %b exp 0000", bus.ringing); end
  endtask

  task automatic test_reset_mid();
    set_time(10); cycle();
    set_time(240); cycle();
    bus.snooze = 1; cycle();
    set_time(150); cycle();
    checks++; if (bus.ringing !== 4'b0100) begin errors++; $display("FAIL mid_pre_ring got %b exp 0100", bus.ringing); end
    #2 reset = 0;
    #1;
    checks++; if (bus.ringing !== 4'b0) begin errors++; $display("FAIL mid_rst_ringing got %b exp 0000", bus.ringing); end
    checks++; if (bus.armed !== 4'b0) begin errors++; $display("FAIL mid_rst_armed got %b exp 0000", bus.armed); end
    checks++; if (bus.alarm_buzzer !== 1'b0) begin errors++; $display("FAIL mid_rst_buzzer got %b exp 0", bus.alarm_buzzer); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
    cycle();
  endtask

  task automatic test_snooze_dismiss_same();
    set_cfg(2, 0, 5, 0, 1, 1); cycle();
    set_time(299); cycle();
    tick();
    checks++; if (bus.ringing !== 4'b0100) begin errors++; $display("FAIL sd_ring got %b exp 0100", bus.ringing); end
    bus.snooze = 1; bus.dismiss = 1; cycle();
    checks++; if (bus.armed !== 4'b0100) begin errors++; $display("FAIL sd_armed got %b exp 0100", bus.armed); end
    repeat (SNZ + 1) tick();
    checks++; if (bus.ringing !== 4'b0000) begin errors++; $display("FAIL sd_no_rering got %b exp 0000", bus.ringing); end
  endtask

  task automatic test_random();
    logic [NA-1:0] er, ea;
    logic [IW-1:0] ei;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 8) begin
        set_cfg(int'($urandom_range(0, 7) > 5 ? $urandom_range(4, 7) : $urandom_range(0, 3)),
                ($urandom_range(0, 99) < 5) ? 24 : 0,
                ($urandom_range(0, 99) < 5) ? 60 : int'($urandom_range(0, 2)),
                int'($urandom_range(0, 59)),
                $urandom_range(0, 9) > 1, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 99) < 3) set_time(int'($urandom_range(0, 180)));
      else if ($urandom_range(0, 99) < 40) begin set_time(t_sec + 1); bus.sec_tick = 1; end
      bus.snooze  = ($urandom_range(0, 99) < 5);
      bus.dismiss = ($urandom_range(0, 99) < 3);
      cycle();
      er = m_mask(M_RING); ea = m_mask(M_ARM); ei = m_idx();
      checks++; if (bus.ringing !== er) begin errors++; $display("FAIL rand_ringing n=%0d got %b exp %b", n, bus.ringing, er); end
      checks++; if (bus.armed !== ea) begin errors++; $display("FAIL rand_armed n=%0d got %b exp %b", n, bus.armed, ea); end
      checks++; if (bus.alarm_buzzer !== (|er)) begin errors++; $display("FAIL rand_buzzer n=%0d got %b exp %b", n, bus.alarm_buzzer, |er); end
      checks++; if (bus.alarm_fired_idx !== ei) begin errors++; $display("FAIL rand_idx n=%0d got %0d exp %0d", n, bus.alarm_fired_idx, ei); end
      checks++; if (bus.invalid_cfg !== m_inv) begin errors++; $display("FAIL rand_invalid n=%0d got %b exp %b", n, bus.invalid_cfg, m_inv); end
    end
  endtask

  initial begin
    bus.sec_tick = 0; bus.cfg_we = 0; bus.cfg_idx = '0;
    bus.cfg_hour = 0; bus.cfg_min = 0; bus.cfg_sec = 0;
    bus.cfg_enable = 0; bus.cfg_repeat = 0; bus.snooze = 0; bus.dismiss = 0;
    set_time(0);
    model_reset();
    test_reset();
    test_one_shot();
    test_dismiss_repeat();
    test_snooze();
    test_multi();
    test_invalid();
    test_reset_mid();
    test_snooze_dismiss_same();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
